// File: rtl/pc_gen_pkg.sv
// Shared types and helpers for the program-counter generator.
package pc_gen_pkg;

  typedef enum logic [1:0] {
    ST_BOOT = 2'd0,
    ST_RUN  = 2'd1,
    ST_HALT = 2'd2
  } pc_state_e;

  localparam logic [31:0] DEFAULT_RESET_VECTOR = 32'h0000_0000;

  // Mask of the address bits that must be zero for an aligned instruction.
  function automatic logic [63:0] insn_low_mask(input int unsigned insn_bytes);
    return 64'(insn_bytes - 1);
  endfunction

endpackage

// File: rtl/pc_gen_next_sel.sv
// Next-PC priority mux: trap, aligned redirect, misaligned redirect, fire, hold.
module pc_next_sel
  import pc_gen_pkg::*;
#(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned INSN_BYTES = 4
) (
  input  logic            active_i,
  input  logic [XLEN-1:0] pc_q_i,
  input  logic            pc_valid_i,
  input  logic            fetch_ready_i,
  input  logic            stall_i,
  input  logic            redirect_valid_i,
  input  logic [XLEN-1:0] redirect_target_i,
  input  logic            trap_valid_i,
  input  logic [XLEN-1:0] trap_vector_i,
  output logic [XLEN-1:0] pc_d_o,
  output logic            misalign_o,
  output logic            fire_o
);

  localparam logic [XLEN-1:0] LOW_MASK = XLEN'(insn_low_mask(INSN_BYTES));
  localparam logic [XLEN-1:0] STEP     = XLEN'(INSN_BYTES);

  logic handshake;
  assign handshake = pc_valid_i & fetch_ready_i & ~stall_i;

  // Priority select; a trap or redirect replaces the pending request, so no fire then.
  always_comb begin
    pc_d_o     = pc_q_i;
    misalign_o = 1'b0;
    fire_o     = 1'b0;
    if (active_i) begin
      if (trap_valid_i) begin
        pc_d_o = trap_vector_i & ~LOW_MASK;
      end else if (redirect_valid_i) begin
        if ((redirect_target_i & LOW_MASK) == '0) begin
          pc_d_o = redirect_target_i;
        end else begin
          misalign_o = 1'b1;
        end
      end else if (handshake) begin
        pc_d_o = pc_q_i + STEP;
        fire_o = 1'b1;
      end
    end
  end

endmodule

// File: rtl/pc_gen.sv
// Program-counter generator: BOOT/RUN/HALT sequencing, PC register, fetch counter.
//   state | meaning
//   BOOT  | one cycle after reset release, inputs ignored
//   RUN   | PC presented as a fetch request
//   HALT  | fetching stopped, trap/redirect still load the PC
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int unsigned     XLEN         = 32,
  parameter logic [XLEN-1:0] RESET_VECTOR = XLEN'(DEFAULT_RESET_VECTOR),
  parameter int unsigned     INSN_BYTES   = 4,
  parameter int unsigned     CNT_W        = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             stall,
  input  logic             fetch_ready,
  input  logic             redirect_valid,
  input  logic [XLEN-1:0]  redirect_target,
  input  logic             trap_valid,
  input  logic [XLEN-1:0]  trap_vector,
  input  logic             halt_req,
  input  logic             resume,
  output logic [XLEN-1:0]  pc_current,
  output logic             pc_valid,
  output logic             misalign_err,
  output logic [XLEN-1:0]  misalign_addr,
  output logic [CNT_W-1:0] fetch_count,
  output logic             halted
);

  pc_state_e        state_q;
  logic             pc_valid_q, halted_q, misalign_q;
  logic [XLEN-1:0]  pc_q, pc_d, maddr_q;
  logic [CNT_W-1:0] cnt_q;
  logic             misalign_d, fire;

  pc_next_sel #(.XLEN(XLEN), .INSN_BYTES(INSN_BYTES)) u_next_sel (
    .active_i          (state_q != ST_BOOT),
    .pc_q_i            (pc_q),
    .pc_valid_i        (pc_valid_q),
    .fetch_ready_i     (fetch_ready),
    .stall_i           (stall),
    .redirect_valid_i  (redirect_valid),
    .redirect_target_i (redirect_target),
    .trap_valid_i      (trap_valid),
    .trap_vector_i     (trap_vector),
    .pc_d_o            (pc_d),
    .misalign_o        (misalign_d),
    .fire_o            (fire)
  );

  // FSM with registered pc_valid/halted; halt wins in RUN, resume wins in HALT.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= ST_BOOT;
      pc_valid_q <= 1'b0;
      halted_q   <= 1'b0;
    end else begin
      case (state_q)
        ST_BOOT: begin
          state_q    <= ST_RUN;
          pc_valid_q <= 1'b1;
          halted_q   <= 1'b0;
        end
        ST_RUN: begin
          if (halt_req) begin
            state_q    <= ST_HALT;
            pc_valid_q <= 1'b0;
            halted_q   <= 1'b1;
          end
        end
        ST_HALT: begin
          if (resume) begin
            state_q    <= ST_RUN;
            pc_valid_q <= 1'b1;
            halted_q   <= 1'b0;
          end
        end
        default: begin
          state_q    <= ST_BOOT;
          pc_valid_q <= 1'b0;
          halted_q   <= 1'b0;
        end
      endcase
    end
  end

  // PC, misalignment capture and fetch counter.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q       <= RESET_VECTOR;
      misalign_q <= 1'b0;
      maddr_q    <= '0;
      cnt_q      <= '0;
    end else begin
      pc_q       <= pc_d;
      misalign_q <= misalign_d;
      if (misalign_d) maddr_q <= redirect_target;
      if (fire)       cnt_q   <= cnt_q + 1'b1;
    end
  end

  assign pc_current    = pc_q;
  assign pc_valid      = pc_valid_q;
  assign misalign_err  = misalign_q;
  assign misalign_addr = maddr_q;
  assign fetch_count   = cnt_q;
  assign halted        = halted_q;

endmodule

// File: tb/tb_pc_gen.sv
// Directed bench for pc_gen; a second instance with 2-byte instructions shares stimulus.
module tb_pc_gen;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall, fetch_ready, redirect_valid, trap_valid, halt_req, resume;
  logic [31:0] redirect_target, trap_vector;
  logic [31:0] pc_current, misalign_addr, fetch_count;
  logic        pc_valid, misalign_err, halted;
  logic [31:0] pc2, maddr2, cnt2;
  logic        valid2, merr2, halted2;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pc_gen dut (
    .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .halt_req(halt_req), .resume(resume),
    .pc_current(pc_current), .pc_valid(pc_valid), .misalign_err(misalign_err),
    .misalign_addr(misalign_addr), .fetch_count(fetch_count), .halted(halted)
  );

  pc_gen #(.INSN_BYTES(2)) dut2 (
    .clk(clk), .rst(rst), .stall(stall), .fetch_ready(fetch_ready),
    .redirect_valid(redirect_valid), .redirect_target(redirect_target),
    .trap_valid(trap_valid), .trap_vector(trap_vector),
    .halt_req(halt_req), .resume(resume),
    .pc_current(pc2), .pc_valid(valid2), .misalign_err(merr2),
    .misalign_addr(maddr2), .fetch_count(cnt2), .halted(halted2)
  );

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b0; stall = 1'b0; fetch_ready = 1'b0; redirect_valid = 1'b0;
    trap_valid = 1'b0; halt_req = 1'b0; resume = 1'b0;
    redirect_target = '0; trap_vector = '0;

    repeat (3) step();
    chk("rst_pc", pc_current, 32'h0);
    chk("rst_valid", {31'b0, pc_valid}, 32'd0);
    chk("rst_halted", {31'b0, halted}, 32'd0);
    chk("rst_count", fetch_count, 32'd0);

    rst = 1'b1; fetch_ready = 1'b1;
    chk("boot_valid", {31'b0, pc_valid}, 32'd0);
    step();
    chk("run_valid", {31'b0, pc_valid}, 32'd1);
    chk("run_pc0", pc_current, 32'h0);
    chk("run_cnt0", fetch_count, 32'd0);
    step(); chk("seq_pc4", pc_current, 32'h4);
    step(); chk("seq_pc8", pc_current, 32'h8);
    step(); chk("seq_pcc", pc_current, 32'hC);
    chk("seq_cnt3", fetch_count, 32'd3);
    step(); chk("seq_pc10", pc_current, 32'h10);

    stall = 1'b1;
    for (int i = 0; i < 2; i++) begin
      step(); chk("stall_pc", pc_current, 32'h10); chk("stall_cnt", fetch_count, 32'd4);
    end
    stall = 1'b0; fetch_ready = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(); chk("bp_pc", pc_current, 32'h10); chk("bp_cnt", fetch_count, 32'd4);
    end
    fetch_ready = 1'b1;
    step(); chk("release_pc", pc_current, 32'h14);
    chk("release_cnt", fetch_count, 32'd5);

    fetch_ready = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h20;
    step(); chk("redir_pc20", pc_current, 32'h20);
    trap_valid = 1'b1; trap_vector = 32'h103; redirect_target = 32'h80;
    step(); chk("trap_prio", pc_current, 32'h100);
    chk("trap_mask2", pc2, 32'h102);
    trap_valid = 1'b0; stall = 1'b1; fetch_ready = 1'b1;
    step(); chk("redir_stall", pc_current, 32'h80);
    chk("redir_stall_cnt", fetch_count, 32'd5);

    stall = 1'b0; fetch_ready = 1'b0; redirect_target = 32'h30;
    step(); chk("redir_pc30", pc_current, 32'h30);
    redirect_target = 32'h42;
    step(); chk("mis_pc_hold", pc_current, 32'h30);
    chk("mis_err", {31'b0, misalign_err}, 32'd1);
    chk("mis_addr", misalign_addr, 32'h42);
    chk("mis2_pc", pc2, 32'h42);
    chk("mis2_err", {31'b0, merr2}, 32'd0);
    redirect_valid = 1'b0;
    step(); chk("mis_err_drop", {31'b0, misalign_err}, 32'd0);
    chk("mis_addr_hold", misalign_addr, 32'h42);

    redirect_valid = 1'b1; redirect_target = 32'h50;
    step(); chk("redir_pc50", pc_current, 32'h50);
    redirect_valid = 1'b0; fetch_ready = 1'b1; halt_req = 1'b1;
    step(); chk("halt_pc", pc_current, 32'h54);
    chk("halt_halted", {31'b0, halted}, 32'd1);
    chk("halt_valid", {31'b0, pc_valid}, 32'd0);
    chk("halt_cnt", fetch_count, 32'd6);
    halt_req = 1'b0; redirect_valid = 1'b1; redirect_target = 32'h200;
    step(); chk("halt_redir", pc_current, 32'h200);
    chk("halt_stays", {31'b0, halted}, 32'd1);
    chk("halt_cnt_frozen", fetch_count, 32'd6);
    redirect_valid = 1'b0; resume = 1'b1;
    step(); chk("resume_halted", {31'b0, halted}, 32'd0);
    chk("resume_valid", {31'b0, pc_valid}, 32'd1);
    chk("resume_pc", pc_current, 32'h200);
    resume = 1'b0;
    step(); chk("resume_adv", pc_current, 32'h204);
    chk("resume_cnt", fetch_count, 32'd7);

    fetch_ready = 1'b0; halt_req = 1'b1; resume = 1'b1;
    step(); chk("both_in_run", {31'b0, halted}, 32'd1);
    step(); chk("both_in_halt", {31'b0, halted}, 32'd0);
    halt_req = 1'b0; resume = 1'b0;

    redirect_valid = 1'b1; redirect_target = 32'hFFFF_FFFC;
    step(); chk("wrap_pre", pc_current, 32'hFFFF_FFFC);
    redirect_valid = 1'b0; fetch_ready = 1'b1;
    step(); chk("wrap_pc", pc_current, 32'h0);
    chk("wrap_cnt", fetch_count, 32'd8);

    stall = 1'b1;
    #3 rst = 1'b0;
    #1;
    chk("arst_pc", pc_current, 32'h0);
    chk("arst_valid", {31'b0, pc_valid}, 32'd0);
    chk("arst_cnt", fetch_count, 32'd0);
    chk("arst_maddr", misalign_addr, 32'h0);
    chk("arst_halted", {31'b0, halted}, 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/pc_gen.md
Name: pc_gen

Overview:
- Parametrised program-counter generator; successor to the single-register PC.
- Owns fetch-address sequencing for the front end and presents the PC to instruction memory with a valid/ready handshake.
- Supports pipeline stall, branch/jump redirect, trap entry, halt/resume, misalignment detection and a fetch counter.
- Sits between the branch/trap logic in the core and the instruction-fetch port.

Parameters:
XLEN, 32, PC and address width in bits
RESET_VECTOR, 32'h0000_0000, PC value loaded on reset (XLEN bits)
INSN_BYTES, 4, sequential increment; legal values 2 or 4; alignment mask derived from it
CNT_W, 32, width of fetch_count

Ports:
clk  in  1  clock, rising edge
rst  in  1  asynchronous reset, active-low (asserted when 0)
stall  in  1  pipeline hold; blocks sequential advance
fetch_ready  in  1  instruction memory accepts current PC
redirect_valid  in  1  branch/jump taken this cycle
redirect_target  in  XLEN  redirect destination
trap_valid  in  1  trap/exception entry this cycle
trap_vector  in  XLEN  trap handler address
halt_req  in  1  request to stop fetching
resume  in  1  request to restart fetching
pc_current  out  XLEN  current fetch address
pc_valid  out  1  pc_current is a fetch request
misalign_err  out  1  one-cycle pulse: rejected misaligned redirect
misalign_addr  out  XLEN  captured offending target
fetch_count  out  CNT_W  number of accepted fetches
halted  out  1  FSM is in HALT

Behaviour:
- One clock domain. rst is asynchronous and active-low. All outputs update on the rising edge of clk.
- Reset values (immediate on rst=0):
  - pc_current = RESET_VECTOR
  - pc_valid = 0, misalign_err = 0, misalign_addr = 0, fetch_count = 0, halted = 0
  - state = BOOT
- Reset asserted mid-operation aborts everything in the same instant; no pending redirect survives.
- FSM states:
  - BOOT: exactly one cycle after reset release; ignores all inputs; goes to RUN.
  - RUN: pc_valid = 1; goes to HALT on halt_req.
  - HALT: pc_valid = 0, halted = 1; goes to RUN on resume.
- Simultaneous halt_req and resume: halt_req wins in RUN; resume wins in HALT.
- Fire is pc_valid & fetch_ready & ~stall. On fire, fetch_count increments by 1, wrapping modulo 2^CNT_W.
- Next-PC priority, evaluated in RUN and HALT:
  1. trap_valid: pc <= trap_vector with low alignment bits forced to 0.
  2. redirect_valid with aligned target: pc <= redirect_target. Overrides stall and fetch_ready, i.e. it flushes the pending request.
  3. redirect_valid with misaligned target (target mod INSN_BYTES != 0): pc holds, misalign_err = 1 for one cycle, misalign_addr <= target. No fire advance occurs that cycle.
  4. fire: pc <= pc_current + INSN_BYTES, modulo 2^XLEN (0xFFFF_FFFC + 4 wraps to 0x0000_0000).
  5. Otherwise pc holds.
- Handshake: while pc_valid = 1 and no fire occurs, pc_current is stable unless a trap or redirect replaces it.
- Latency: a redirect or trap presented in cycle N appears on pc_current in cycle N+1. A fire in cycle N gives PC+INSN_BYTES in cycle N+1.
- Halt with fire in the same cycle: the fire completes (PC advances, count increments), then the FSM enters HALT.
- In HALT, trap and redirect still update pc_current; the FSM stays in HALT.
- misalign_err deasserts the cycle after its pulse. misalign_addr holds its value until the next error or reset.

Decomposition:
- Shared package holds:
  - the state enum (BOOT, RUN, HALT);
  - the default RESET_VECTOR;
  - the INSN_BYTES alignment-mask function.
- One sub-module, pc_next_sel: combinational priority mux plus alignment check. Outputs next PC, misalign flag and fire.
- pc_gen itself holds the FSM, the registers and the counter.

Test Plan:
- Reset and boot: rst=0 for 3 cycles, then release with fetch_ready=1 → pc_current=0x0, pc_valid=0 for one cycle, then valid. Following cycles give 0x0, 0x4, 0x8; fetch_count=3 after three fires.
- Stall and backpressure: at pc=0x10, assert stall for 2 cycles, then fetch_ready=0 for 2 cycles → pc stays 0x10 and count is frozen. Both released → 0x14 on the next cycle.
- Priority and redirect: at pc=0x20, trap_valid (vector 0x103) and redirect_valid (target 0x80) in the same cycle → pc=0x100. Next, redirect to 0x80 with stall=1 → pc=0x80.
- Misalignment: redirect to 0x42 at pc=0x30 → pc stays 0x30, misalign_err pulses for 1 cycle, misalign_addr=0x42. Repeat with INSN_BYTES=2 → 0x42 is accepted.
- Halt/resume: halt_req with fire at pc=0x50 → pc=0x54, halted=1, pc_valid=0. Redirect to 0x200 while halted → pc=0x200, still halted. resume → fetch resumes at 0x200.
- Wrap and reset mid-run: redirect to 0xFFFF_FFFC, then fire → pc=0x0. Assert rst=0 between clock edges → outputs return to reset values immediately.
